// File: rtl/alu_issue_ctrl_if.sv
// Command channel between an issuing agent and alu_issue_ctrl.
// Purely combinational bundle; no storage.
// Backpressure: cmd_ready from the controller gates acceptance of cmd_valid.
interface alu_issue_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_sel;
  logic [1:0] cmd_rd;
  logic [1:0] cmd_ra;
  logic [1:0] cmd_rb;
  logic       cmd_cin;
  logic       cmd_use_carry;
  logic       cmd_use_imm;
  logic [3:0] cmd_imm;

  modport master (
    output cmd_valid, cmd_sel, cmd_rd, cmd_ra, cmd_rb,
           cmd_cin, cmd_use_carry, cmd_use_imm, cmd_imm,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_sel, cmd_rd, cmd_ra, cmd_rb,
           cmd_cin, cmd_use_carry, cmd_use_imm, cmd_imm,
    output cmd_ready
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues commands to a registered 4-bit ALU from a 4x4 register file, writes back f/cout.
// Latency: accept at E0, ALU registers at E1, writeback at E2, res_valid the cycle after.
// Backpressure: cmd_ready only in IDLE (one command per 3 cycles); results never stall.
// Optional ALU_CTRL_IMM_EN: when defined, cmd_use_imm selects cmd_imm as operand B.
module alu_issue_ctrl (
  input  logic             clk,
  input  logic             reset_n,
  alu_issue_ctrl_if.slave  cmd,
  input  logic             ld_en,
  input  logic [1:0]       ld_addr,
  input  logic [3:0]       ld_data,
  output logic [2:0]       alu_sel,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic             alu_cin,
  input  logic [3:0]       alu_f,
  input  logic             alu_cout,
  output logic             res_valid,
  output logic [3:0]       res_data,
  output logic             res_cout,
  output logic             carry_flag
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] rf [4];
  logic [1:0] rd_q;
  logic       accept;
  logic       wb_en;
  logic [3:0] opb;

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // next-state: accept -> EXEC -> WB -> IDLE, fixed three-cycle walk
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs; ready is masked by reset so it reads 0 while reset is held
  always_comb begin
    cmd.cmd_ready = reset_n && (state == IDLE);
    wb_en         = (state == WB);
  end

  assign accept = cmd.cmd_valid && cmd.cmd_ready;

`ifdef ALU_CTRL_IMM_EN
  // operand B: immediate when requested, otherwise register file
  always_comb begin
    opb = cmd.cmd_use_imm ? cmd.cmd_imm : rf[cmd.cmd_rb];
  end
`else
  logic unused_imm;
  assign unused_imm = ^{cmd.cmd_use_imm, cmd.cmd_imm};

  // operand B always comes from the register file in this build
  always_comb begin
    opb = rf[cmd.cmd_rb];
  end
`endif

  // ALU inputs load on accept and stay put through EXEC and WB
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_sel <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_cin <= 1'b0;
      rd_q    <= '0;
    end else if (accept) begin
      alu_sel <= cmd.cmd_sel;
      alu_a   <= rf[cmd.cmd_ra];
      alu_b   <= opb;
      alu_cin <= cmd.cmd_use_carry ? carry_flag : cmd.cmd_cin;
      rd_q    <= cmd.cmd_rd;
    end
  end

  // register file: writeback is written after the load so it wins on a same-index collision
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) rf[i] <= '0;
    end else begin
      if (ld_en) rf[ld_addr] <= ld_data;
      if (wb_en) rf[rd_q]    <= alu_f;
    end
  end

  // result pulse, held result value and chaining carry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_cout   <= 1'b0;
      carry_flag <= 1'b0;
    end else begin
      res_valid <= wb_en;
      if (wb_en) begin
        res_data   <= alu_f;
        res_cout   <= alu_cout;
        carry_flag <= alu_cout;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios then random commands/loads,
// compared against a plain-arithmetic model of the register file and carry flag.
// A registered adder stands in for the ALU.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [3:0] ld_data;
  logic [2:0] alu_sel;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic       alu_cin;
  logic [3:0] alu_f;
  logic       alu_cout;
  logic       res_valid;
  logic [3:0] res_data;
  logic       res_cout;
  logic       carry_flag;

  int errors = 0;
  int checks = 0;

  logic [3:0] rf_m [4];
  logic       carry_m;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd        (bus.slave),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .alu_sel    (alu_sel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cin    (alu_cin),
    .alu_f      (alu_f),
    .alu_cout   (alu_cout),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_cout   (res_cout),
    .carry_flag (carry_flag)
  );

  always #5 clk = ~clk;

  // bench ALU: f = a + b + cin, one register stage
  always @(posedge clk) begin
    {alu_cout, alu_f} <= {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) rf_m[i] = 4'h0;
    carry_m = 1'b0;
  endtask

  // direct load; called and returns at a negedge
  task automatic load(input logic [1:0] addr, input logic [3:0] data);
    ld_en = 1'b1; ld_addr = addr; ld_data = data;
    @(posedge clk);
    @(negedge clk);
    ld_en = 1'b0;
    rf_m[addr] = data;
  endtask

  // one command with optional load on its writeback edge; called and returns at a negedge
  task automatic issue(input logic [2:0] sel, input logic [1:0] rd, input logic [1:0] ra,
                       input logic [1:0] rb, input logic cin, input logic uc, input logic ui,
                       input logic [3:0] imm, input logic wl, input logic [1:0] wl_addr,
                       input logic [3:0] wl_data);
    logic [3:0] a_e, b_e;
    logic       c_e;
    int         sum;
    a_e = rf_m[ra];
`ifdef ALU_CTRL_IMM_EN
    b_e = ui ? imm : rf_m[rb];
`else
    b_e = rf_m[rb];
`endif
    c_e = uc ? carry_m : cin;
    sum = int'(a_e) + int'(b_e) + int'(c_e);

    bus.cmd_valid = 1'b1; bus.cmd_sel = sel; bus.cmd_rd = rd; bus.cmd_ra = ra;
    bus.cmd_rb = rb; bus.cmd_cin = cin; bus.cmd_use_carry = uc;
    bus.cmd_use_imm = ui; bus.cmd_imm = imm;
    chk("ready_idle", {7'b0, bus.cmd_ready}, 8'h1);
    @(posedge clk);                       // E0: accept
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_sel = $urandom; bus.cmd_ra = $urandom; bus.cmd_rb = $urandom;
    bus.cmd_cin = $urandom; bus.cmd_use_carry = $urandom; bus.cmd_imm = $urandom;
    chk("alu_sel",   {5'b0, alu_sel}, {5'b0, sel});
    chk("alu_a",     {4'b0, alu_a}, {4'b0, a_e});
    chk("alu_b",     {4'b0, alu_b}, {4'b0, b_e});
    chk("alu_cin",   {7'b0, alu_cin}, {7'b0, c_e});
    chk("ready_exec", {7'b0, bus.cmd_ready}, 8'h0);
    chk("rv_exec",   {7'b0, res_valid}, 8'h0);
    @(posedge clk);                       // E1: ALU registers
    @(negedge clk);
    chk("alu_a_hold", {4'b0, alu_a}, {4'b0, a_e});
    chk("alu_b_hold", {4'b0, alu_b}, {4'b0, b_e});
    chk("rv_wb",     {7'b0, res_valid}, 8'h0);
    if (wl) begin
      ld_en = 1'b1; ld_addr = wl_addr; ld_data = wl_data;
    end
    @(posedge clk);                       // E2: writeback
    @(negedge clk);
    ld_en = 1'b0;
    if (wl) rf_m[wl_addr] = wl_data;
    rf_m[rd] = sum[3:0];
    carry_m  = sum[4];
    chk("res_valid", {7'b0, res_valid}, 8'h1);
    chk("res_data",  {4'b0, res_data}, {4'b0, sum[3:0]});
    chk("res_cout",  {7'b0, res_cout}, {7'b0, sum[4]});
    chk("carry_flag", {7'b0, carry_flag}, {7'b0, sum[4]});
    chk("ready_after", {7'b0, bus.cmd_ready}, 8'h1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, {7'b0, bus.cmd_ready}, 8'h0);
    chk({tag, "_alu"},   {alu_sel, alu_a, alu_cin}, 8'h0);
    chk({tag, "_alub"},  {4'b0, alu_b}, 8'h0);
    chk({tag, "_res"},   {2'b0, res_valid, res_data, res_cout}, 8'h0);
    chk({tag, "_carry"}, {7'b0, carry_flag}, 8'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    ld_en = 1'b1; ld_addr = 2'd1; ld_data = 4'hA;
    bus.cmd_valid = 1'b1; bus.cmd_sel = 3'd5; bus.cmd_rd = 2'd2; bus.cmd_ra = 2'd1;
    bus.cmd_rb = 2'd1; bus.cmd_cin = 1'b1; bus.cmd_use_carry = 1'b0;
    bus.cmd_use_imm = 1'b0; bus.cmd_imm = 4'h0;
    model_reset();

    // reset sweep with active-looking inputs
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    ld_en = 1'b0; bus.cmd_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rel_ready", {7'b0, bus.cmd_ready}, 8'h1);
    chk("rel_carry", {7'b0, carry_flag}, 8'h0);
    @(negedge clk);

    // basic add, then read the destination back
    load(2'd0, 4'h3);
    load(2'd1, 4'h5);
    issue(3'd0, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0);
    chk("r2_model", {4'b0, rf_m[2]}, 8'h08);
    issue(3'd1, 2'd3, 2'd2, 2'd3, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0);

    // carry chain
    load(2'd3, 4'h0);
    load(2'd0, 4'hF);
    load(2'd1, 4'h1);
    issue(3'd0, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0);
    issue(3'd2, 2'd3, 2'd3, 2'd3, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0);
    chk("chain_r3", {4'b0, rf_m[3]}, 8'h01);

    // writeback/load collisions: same index, then different index, then read back
    issue(3'd0, 2'd1, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 2'd1, 4'h9);
    issue(3'd0, 2'd2, 2'd1, 2'd1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 2'd0, 4'h7);
    issue(3'd0, 2'd3, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0);

    // immediate operand (falls back to reg[rb] without the feature)
    load(2'd0, 4'h2);
    load(2'd1, 4'h9);
    issue(3'd0, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0, 1'b1, 4'h6, 1'b0, 2'd0, 4'h0);

    // reset while the command is in EXEC
    load(2'd0, 4'hE);
    load(2'd1, 4'h3);
    bus.cmd_valid = 1'b1; bus.cmd_sel = 3'd0; bus.cmd_rd = 2'd3; bus.cmd_ra = 2'd0;
    bus.cmd_rb = 2'd1; bus.cmd_cin = 1'b1; bus.cmd_use_carry = 1'b0; bus.cmd_use_imm = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_all_zero("rst_exec");
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    #1;
    chk("rst_exec_ready", {7'b0, bus.cmd_ready}, 8'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_exec_norv", {7'b0, res_valid}, 8'h0);
    end
    issue(3'd0, 2'd0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 4'h0);

    // random mix of loads and commands, some with writeback-edge loads
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0)
        load(2'($urandom), 4'($urandom));
      else
        issue(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 4'($urandom), ($urandom_range(0, 2) == 0),
              2'($urandom), 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
